// File: rtl/usb20sr_refdes_avmm_cmd_master.sv
// Single-outstanding Avalon-MM master: turns one command into one read/write transfer
// and returns a single response, aborting with rsp_err if the slave stalls too long.
module usb20sr_refdes_avmm_cmd_master #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [3:0]        be_q, be_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              tmo;

    // Counter reaches TIMEOUT on the edge that ends this cycle.
    assign tmo = (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    be_d    = cmd_be;
                    rd_d    = ~cmd_write;
                    wr_d    = cmd_write;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 16'd1;
                if (!avm_waitrequest) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    // Completion is checked before timeout so a late success still wins.
                    if (wr_q) begin
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else if (avm_readdatavalid) begin
                        rdata_d = avm_readdata;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else if (tmo) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = RDWAIT;
                    end
                end else if (tmo) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RDWAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (avm_readdatavalid) begin
                    rdata_d = avm_readdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign rsp_valid      = (state_q == RESP);
    assign rsp_rdata      = rdata_q;
    assign rsp_err        = err_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;

endmodule

// File: tb/tb_usb20sr_refdes_avmm_cmd_master.sv
// Directed bench for the Avalon-MM command master, with a small memory slave whose
// wait states and read latency are set per test.
module tb_usb20sr_refdes_avmm_cmd_master;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [3:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    usb20sr_refdes_avmm_cmd_master #(.ADDR_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Slave knobs and observations
    int          ws = 0, lat = 0, pend = 0, wcnt = 0;
    int          strobe_cycles = 0, strobe_bad = 0;
    bit          no_rdv = 0, spur = 0, overlap = 0;
    logic [31:0] rd_hold;
    logic [31:0] mem [16];
    logic [3:0]  exp_addr, exp_be;
    logic [31:0] exp_wdata;
    logic        exp_wr;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0; rd_hold = '0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 0;
            avm_readdata = '0;
            if (!reset_n) begin
                wcnt = 0; pend = 0; avm_waitrequest = 0;
            end else begin
                if (avm_read && avm_write) overlap = 1;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin avm_readdatavalid = 1; avm_readdata = rd_hold; end
                end
                if (spur) begin
                    avm_readdatavalid = 1; avm_readdata = 32'hDEAD_BEEF; spur = 0;
                end
                if (avm_read || avm_write) begin
                    strobe_cycles++;
                    if (avm_address != exp_addr || avm_write != exp_wr || avm_byteenable != exp_be ||
                        (exp_wr && avm_writedata != exp_wdata)) strobe_bad++;
                    if (wcnt < ws) begin
                        avm_waitrequest = 1; wcnt++;
                    end else begin
                        avm_waitrequest = 0; wcnt = 0;
                        if (avm_write) begin
                            for (int b = 0; b < 4; b++)
                                if (avm_byteenable[b]) mem[avm_address][8*b +: 8] = avm_writedata[8*b +: 8];
                        end else if (!no_rdv) begin
                            if (lat == 0) begin
                                avm_readdatavalid = 1; avm_readdata = mem[avm_address];
                            end else begin
                                pend = lat; rd_hold = mem[avm_address];
                            end
                        end
                    end
                end else begin
                    avm_waitrequest = 0; wcnt = 0;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_addr = a; exp_wdata = d; exp_be = be; exp_wr = wr;
        strobe_cycles = 0; strobe_bad = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_be = be;
        for (int n = 0; n < 20 && !cmd_ready; n++) @(negedge clk);
        if (!cmd_ready) chk("cmd_ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    // lat_o counts negedges after the accepting edge at which rsp_valid is first seen.
    task automatic wait_rsp(output int lat_o, output logic [31:0] rd_o, output logic err_o);
        lat_o = 1;
        while (!rsp_valid && lat_o < 40) begin @(negedge clk); lat_o++; end
        if (!rsp_valid) chk("rsp_wait", 32'd0, 32'd1);
        rd_o = rsp_rdata; err_o = rsp_err;
    endtask

    task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                        output int lat_o, output logic [31:0] rd_o, output logic err_o);
        send_cmd(wr, a, d, be);
        wait_rsp(lat_o, rd_o, err_o);
        @(negedge clk);
    endtask

    int          l;
    logic [31:0] rd;
    logic        er;
    logic [31:0] b2b [4];
    int          quiet;

    initial begin
        b2b[0] = 32'h1357_9BDF; b2b[1] = 32'h2468_ACE0; b2b[2] = 32'hCAFE_F00D; b2b[3] = 32'h0BAD_C0DE;
        reset_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        rsp_ready = 1; exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_wr = 0;
        repeat (2) @(negedge clk);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_addr_be_wd", {avm_address, avm_byteenable, 24'd0} | avm_writedata, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        reset_n = 1;
        @(negedge clk);

        // Zero-wait write: one strobe cycle, response two cycles after handshake
        ws = 0; lat = 0;
        xfer(1, 4'd0, 32'h1, 4'hF, l, rd, er);
        chk("wr_lat", l, 2);
        chk("wr_rdata", rd, 0);
        chk("wr_err", 32'(er), 0);
        chk("wr_strobes", strobe_cycles, 1);
        chk("wr_stable", strobe_bad, 0);

        // Read with 3 wait states, data 2 cycles after acceptance
        ws = 3; lat = 2;
        xfer(0, 4'd0, 32'h0, 4'hF, l, rd, er);
        chk("rd_ws_strobes", strobe_cycles, 4);
        chk("rd_ws_stable", strobe_bad, 0);
        chk("rd_ws_rdata", rd, 32'h1);
        chk("rd_ws_err", 32'(er), 0);
        chk("rd_ws_lat", l, 7);

        // Partial byte enables, then read with data in the accept cycle
        ws = 0; lat = 0;
        xfer(1, 4'd5, 32'hAABB_CCDD, 4'hF, l, rd, er);
        xfer(1, 4'd5, 32'h1122_3344, 4'h5, l, rd, er);
        xfer(0, 4'd5, 32'h0, 4'h3, l, rd, er);
        chk("be_rdata", rd, 32'hAA22_CC44);
        chk("rd_same_cycle_lat", l, 2);

        // Read timeout: no readdatavalid ever
        no_rdv = 1;
        send_cmd(0, 4'd0, 32'h0, 4'hF);
        wait_rsp(l, rd, er);
        chk("tmo_rd_err", 32'(er), 1);
        chk("tmo_rd_rdata", rd, 0);
        chk("tmo_rd_lat", l, 9);
        chk("tmo_rd_strobes_off", 32'({avm_read, avm_write}), 0);
        @(negedge clk);
        no_rdv = 0;

        // Write stuck in waitrequest times out after 8 strobe cycles
        ws = 20;
        xfer(1, 4'd6, 32'h5555_AAAA, 4'hF, l, rd, er);
        chk("tmo_wr_err", 32'(er), 1);
        chk("tmo_wr_strobes", strobe_cycles, 8);
        chk("tmo_wr_lat", l, 9);
        chk("tmo_wr_mem_untouched", mem[6], 0);
        ws = 0;

        // Data arrives on the cycle the counter reaches TIMEOUT: completion wins
        lat = 7;
        xfer(0, 4'd0, 32'h0, 4'hF, l, rd, er);
        chk("race_err", 32'(er), 0);
        chk("race_rdata", rd, 32'h1);
        chk("race_lat", l, 9);
        // One cycle later is a timeout; the late data lands in RESP and is ignored
        lat = 8;
        xfer(0, 4'd0, 32'h0, 4'hF, l, rd, er);
        chk("late_err", 32'(er), 1);
        chk("late_rdata", rd, 0);
        lat = 0;

        // Stray readdatavalid while idle
        spur = 1;
        repeat (2) @(negedge clk);
        chk("spur_rsp_valid", 32'(rsp_valid), 0);
        chk("spur_cmd_ready", 32'(cmd_ready), 1);

        // Response back-pressure with a new command pending
        rsp_ready = 0;
        send_cmd(0, 4'd5, 32'h0, 4'hF);
        wait_rsp(l, rd, er);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd7; cmd_wdata = 32'h7777_7777; cmd_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rdata", rsp_rdata, 32'hAA22_CC44);
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
            chk("bp_no_strobe", 32'({avm_read, avm_write}), 0);
        end
        cmd_valid = 0; rsp_ready = 1;
        @(negedge clk);
        chk("bp_mem7_untouched", mem[7], 0);

        // Reset in the middle of a stalled read
        ws = 50;
        send_cmd(0, 4'd0, 32'h0, 4'hF);
        chk("mid_read_on", 32'(avm_read), 1);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_read", 32'(avm_read), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        reset_n = 1; ws = 0;
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid || avm_read || avm_write || !cmd_ready) quiet++;
        end
        chk("post_rst_quiet", quiet, 0);

        // Command presented while in reset is taken on the first edge after release
        reset_n = 0;
        exp_addr = 4'd2; exp_wdata = 32'h0000_00A5; exp_be = 4'hF; exp_wr = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd2; cmd_wdata = 32'h0000_00A5; cmd_be = 4'hF;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk("first_edge_accept", 32'(avm_write), 1);
        cmd_valid = 0;
        wait_rsp(l, rd, er);
        chk("first_edge_lat", l, 2);
        @(negedge clk);
        chk("first_edge_mem", mem[2], 32'h0000_00A5);

        // Back-to-back writes then reads, mixed slave timing
        ws = 1; lat = 1;
        for (int i = 0; i < 4; i++) xfer(1, 4'(8 + i), b2b[i], 4'hF, l, rd, er);
        ws = 0; lat = 3;
        for (int i = 0; i < 4; i++) begin
            xfer(0, 4'(8 + i), 32'h0, 4'hF, l, rd, er);
            chk("b2b_rdata", rd, b2b[i]);
            chk("b2b_err", 32'(er), 0);
        end
        chk("no_overlap", 32'(overlap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/usb20sr_refdes_avmm_cmd_master.md
USB20SR_REFDES_AVMM_CMD_MASTER -- requirements
Module: usb20sr_refdes_avmm_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, width of Avalon-MM word address.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waited per transfer before abort (1..65535).
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when valid&ready.
REQ-007 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  target word address.
REQ-009 SHALL have port cmd_wdata  input  32  write data.
REQ-010 SHALL have port cmd_be  input  4  byte enables.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when valid&ready.
REQ-013 SHALL have port rsp_rdata  output  32  read data (0 for writes/timeouts).
REQ-014 SHALL have port rsp_err  output  1  1=transfer timed out.
REQ-015 SHALL have ports avm_address (output ADDR_W), avm_read (output 1), avm_write (output 1), avm_writedata (output 32), avm_byteenable (output 4): Avalon-MM master command.
REQ-016 SHALL have ports avm_waitrequest (input 1), avm_readdata (input 32), avm_readdatavalid (input 1): Avalon-MM master response.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, RDWAIT, RESP.
REQ-018 cmd_ready SHALL equal (state==IDLE); no combinational path from cmd_valid.
REQ-019 IDLE, cmd_valid=1: SHALL register addr/wdata/be/write, go ISSUE, assert avm_read or avm_write next cycle.
REQ-020 ISSUE: avm_address/writedata/byteenable and read/write strobe SHALL be held stable while avm_waitrequest=1.
REQ-021 ISSUE, avm_waitrequest=0, write: SHALL deassert strobe next cycle, go RESP with rsp_rdata=0, rsp_err=0.
REQ-022 ISSUE, avm_waitrequest=0, read: SHALL deassert strobe next cycle, go RDWAIT; if avm_readdatavalid=1 in the same cycle, SHALL capture avm_readdata and go RESP directly.
REQ-023 RDWAIT: on avm_readdatavalid=1 SHALL capture avm_readdata into rsp_rdata, rsp_err=0, go RESP.
REQ-024 avm_readdatavalid outside ISSUE/RDWAIT SHALL be ignored.
REQ-025 Timeout counter SHALL clear on command accept, increment each cycle in ISSUE/RDWAIT; on reaching TIMEOUT SHALL drop strobes, go RESP with rsp_err=1, rsp_rdata=0.
REQ-026 Completion and timeout in the same cycle: completion SHALL win (rsp_err=0).
REQ-027 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready=1; then IDLE next cycle.
REQ-028 Min command-to-response latency: write with waitrequest=0 -> rsp_valid 2 cycles after accept edge.
REQ-029 At most one outstanding transfer; avm_read and avm_write SHALL never be 1 together.
REQ-030 Avalon strobes SHALL be registered outputs, glitch-free.

Reset
REQ-031 reset_n=0 SHALL asynchronously force state IDLE, avm_read=0, avm_write=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, avm_address=0, avm_writedata=0, avm_byteenable=0, counter=0.
REQ-032 Reset mid-transfer SHALL abandon it; no response issued after release.
REQ-033 First command SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-034 Write addr 0, wdata 0x1, be 0xF, waitrequest=0 -> one avm_write cycle, avm_writedata=0x1; rsp_valid, rdata=0, err=0.
REQ-035 Read addr 0, waitrequest 3 cycles, readdatavalid 2 cycles later data 0x00000001 -> strobe held 4 cycles stable; rsp_rdata=0x1, err=0.
REQ-036 Read, readdatavalid never asserted, TIMEOUT=8 -> rsp_err=1, rsp_rdata=0 after 8 cycles; strobes 0.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp_valid/data stable, cmd_ready=0, no new avm strobe.
REQ-038 reset_n pulsed low while in ISSUE with waitrequest=1 -> avm_read=0 immediately, rsp_valid=0, IDLE after release.
REQ-039 Back-to-back commands with rsp_ready=1 -> every transfer completes, strobes never overlap, order preserved.
